// File: rtl/knn_distance_engine.sv
// Streams per-sample distances (sample vs. test vector) read from synchronous memories to the k-best selector.
// Define KNN_DIST_SQUARED_EN for squared Euclidean distance; Manhattan distance otherwise.
module knn_distance_engine #(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_FEATURES    = 8,
  parameter int NUM_SAMPLES     = 100,
  parameter int DISTANCE_WIDTH  = 32,
  parameter int INDEX_WIDTH     = 8,
  parameter int SMEM_ADDR_WIDTH = 10,
  localparam int FW = $clog2(NUM_FEATURES),
  localparam int CW = $clog2(NUM_FEATURES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [INDEX_WIDTH-1:0]     cfg_num_samples,
  input  logic [CW-1:0]              cfg_num_features,
  output logic                       sample_ren,
  output logic [SMEM_ADDR_WIDTH-1:0] sample_raddr,
  input  logic [DATA_WIDTH-1:0]      sample_rdata,
  output logic                       test_ren,
  output logic [FW-1:0]              test_raddr,
  input  logic [DATA_WIDTH-1:0]      test_rdata,
  output logic                       dist_valid,
  output logic [DISTANCE_WIDTH-1:0]  dist_data,
  output logic [INDEX_WIDTH-1:0]     dist_index,
  input  logic                       dist_ready,
  output logic                       busy,
  output logic                       done
);

`ifdef KNN_DIST_SQUARED_EN
  localparam int TW = 2 * DATA_WIDTH;
`else
  localparam int TW = DATA_WIDTH;
`endif
  localparam int SW = ((TW > DISTANCE_WIDTH) ? TW : DISTANCE_WIDTH) + 1;
  localparam logic [DISTANCE_WIDTH-1:0] DIST_MAX = '1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUTPUT} state_e;

  state_e                     state_q, state_d;
  logic [FW-1:0]              f_q, f_d;
  logic [INDEX_WIDTH-1:0]     s_q, s_d;
  logic [INDEX_WIDTH-1:0]     ns_q, ns_d;
  logic [CW-1:0]              nf_q, nf_d;
  logic [SMEM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [SMEM_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DISTANCE_WIDTH-1:0]  acc_q, acc_d;
  logic                       ren_q, ren_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       done_q, done_d;

  logic [DATA_WIDTH-1:0]      diff;
  logic [TW-1:0]              term;
  logic [SW-1:0]              sum;
  logic [DISTANCE_WIDTH-1:0]  acc_sat;
  logic [CW-1:0]              cfg_nf_eff;
  logic [INDEX_WIDTH-1:0]     cfg_ns_eff;
  logic                       f_last;

  // Per-feature term and saturating sum; the sum is one bit wider so overflow is visible.
  always_comb begin
    diff = (sample_rdata >= test_rdata) ? (sample_rdata - test_rdata)
                                        : (test_rdata - sample_rdata);
`ifdef KNN_DIST_SQUARED_EN
    term = TW'(diff) * TW'(diff);
`else
    term = diff;
`endif
    sum     = SW'(acc_q) + SW'(term);
    acc_sat = (sum > SW'(DIST_MAX)) ? DIST_MAX : sum[DISTANCE_WIDTH-1:0];
  end

  assign cfg_nf_eff = ((cfg_num_features == '0) || (cfg_num_features > CW'(NUM_FEATURES)))
                      ? CW'(NUM_FEATURES) : cfg_num_features;
  assign cfg_ns_eff = (cfg_num_samples > INDEX_WIDTH'(NUM_SAMPLES))
                      ? INDEX_WIDTH'(NUM_SAMPLES) : cfg_num_samples;
  assign f_last     = (CW'(f_q) + CW'(1)) == nf_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    f_d        = f_q;
    s_d        = s_q;
    ns_d       = ns_q;
    nf_d       = nf_q;
    base_d     = base_q;
    raddr_d    = raddr_q;
    acc_d      = acc_q;
    ren_d      = 1'b0;
    rd_valid_d = ren_q;
    done_d     = 1'b0;

    // Read data is only meaningful in the cycle after a read was issued.
    if (rd_valid_q) acc_d = acc_sat;

    if (abort) begin
      state_d    = IDLE;
      acc_d      = '0;
      f_d        = '0;
      rd_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ns_d   = cfg_ns_eff;
            nf_d   = cfg_nf_eff;
            acc_d  = '0;
            s_d    = '0;
            base_d = '0;
            f_d    = '0;
            if (cfg_ns_eff == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = FETCH;
              ren_d   = 1'b1;
              raddr_d = '0;
            end
          end
        end
        FETCH: begin
          if (f_last) begin
            state_d = DRAIN;
          end else begin
            f_d     = f_q + FW'(1);
            ren_d   = 1'b1;
            raddr_d = base_q + SMEM_ADDR_WIDTH'(f_q) + SMEM_ADDR_WIDTH'(1);
          end
        end
        DRAIN: state_d = OUTPUT;
        OUTPUT: begin
          if (dist_ready) begin
            if ((s_q + INDEX_WIDTH'(1)) == ns_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
              s_d     = s_q + INDEX_WIDTH'(1);
              base_d  = base_q + SMEM_ADDR_WIDTH'(NUM_FEATURES);
              raddr_d = base_q + SMEM_ADDR_WIDTH'(NUM_FEATURES);
              acc_d   = '0;
              f_d     = '0;
              ren_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      f_q        <= '0;
      s_q        <= '0;
      ns_q       <= '0;
      nf_q       <= '0;
      base_q     <= '0;
      raddr_q    <= '0;
      acc_q      <= '0;
      ren_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      s_q        <= s_d;
      ns_q       <= ns_d;
      nf_q       <= nf_d;
      base_q     <= base_d;
      raddr_q    <= raddr_d;
      acc_q      <= acc_d;
      ren_q      <= ren_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign sample_ren   = ren_q;
  assign test_ren     = ren_q;
  assign sample_raddr = raddr_q;
  assign test_raddr   = f_q;
  assign dist_valid   = (state_q == OUTPUT);
  assign dist_data    = acc_q;
  assign dist_index   = s_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_knn_distance_engine.sv
// Directed bench for knn_distance_engine with synchronous-read memory models.
// Expected distances follow KNN_DIST_SQUARED_EN when it is defined.
module tb_knn_distance_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, dist_ready;
  logic [7:0]  cfg_num_samples;
  logic [3:0]  cfg_num_features;
  logic        sample_ren, test_ren;
  logic [9:0]  sample_raddr;
  logic [2:0]  test_raddr;
  logic [15:0] sample_rdata, test_rdata;
  logic        dist_valid, busy, done;
  logic [31:0] dist_data;
  logic [7:0]  dist_index;

  logic [15:0] sample_mem [0:1023];
  logic [15:0] test_mem   [0:7];
  int          rd_cnt     [0:23];
  int          rd_total;
  logic        clr_cnt;
  int          passes = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  knn_distance_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_num_samples(cfg_num_samples), .cfg_num_features(cfg_num_features),
    .sample_ren(sample_ren), .sample_raddr(sample_raddr), .sample_rdata(sample_rdata),
    .test_ren(test_ren), .test_raddr(test_raddr), .test_rdata(test_rdata),
    .dist_valid(dist_valid), .dist_data(dist_data), .dist_index(dist_index),
    .dist_ready(dist_ready), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (sample_ren) sample_rdata <= sample_mem[sample_raddr];
    if (test_ren)   test_rdata   <= test_mem[test_raddr];
  end

  always @(posedge clk) begin
    if (clr_cnt) begin
      rd_total <= 0;
      for (int i = 0; i < 24; i++) rd_cnt[i] <= 0;
    end else if (sample_ren) begin
      rd_total <= rd_total + 1;
      if (sample_raddr < 10'd24) rd_cnt[sample_raddr] <= rd_cnt[sample_raddr] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 30 && !dist_valid; i++) step();
    check(tag, 32'(dist_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] exp3 [3];
    logic [31:0] bp_data;
    int          bad;
`ifdef KNN_DIST_SQUARED_EN
    exp3 = '{32'd204, 32'd816, 32'd1836};
`else
    exp3 = '{32'd36, 32'd72, 32'd108};
`endif
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dist_ready = 1'b0; clr_cnt = 1'b1;
    cfg_num_samples = '0; cfg_num_features = '0;
    for (int i = 0; i < 1024; i++) sample_mem[i] = '0;
    for (int i = 0; i < 8; i++) test_mem[i] = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(dist_valid), 32'd0);
    check("rst_ren", 32'({sample_ren, test_ren}), 32'd0);
    check("rst_data", dist_data, 32'd0);
    rst_n = 1'b1;
    step();
    clr_cnt = 1'b0;

    // Two features, one sample: |13-10| + |15-20|.
    test_mem[0] = 16'd10; test_mem[1] = 16'd20;
    sample_mem[0] = 16'd13; sample_mem[1] = 16'd15;
    cfg_num_samples = 8'd1; cfg_num_features = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_c1_ren", 32'({sample_ren, test_ren}), 32'd3);
    check("t1_c1_addr", 32'(sample_raddr), 32'd0);
    check("t1_c1_busy", 32'(busy), 32'd1);
    step();
    check("t1_c2_addr", 32'({sample_raddr, 1'b0, test_raddr}), 32'({10'd1, 1'b0, 3'd1}));
    step();
    check("t1_c3_drain", 32'({sample_ren, dist_valid}), 32'd0);
    step();
    check("t1_c4_valid", 32'(dist_valid), 32'd1);
`ifdef KNN_DIST_SQUARED_EN
    check("t1_c4_data", dist_data, 32'd34);
`else
    check("t1_c4_data", dist_data, 32'd8);
`endif
    check("t1_c4_index", 32'(dist_index), 32'd0);
    dist_ready = 1'b1;
    step();
    check("t1_c5_done", 32'(done), 32'd1);
    check("t1_c5_busy", 32'(busy), 32'd0);
    step();
    check("t1_c6_done", 32'(done), 32'd0);

    // Three samples, cfg_num_features=0 means all 8; odd features sit below the test value.
    for (int f = 0; f < 8; f++) test_mem[f] = 16'd100;
    for (int s = 0; s < 3; s++)
      for (int f = 0; f < 8; f++)
        sample_mem[s*8+f] = (f % 2 == 1) ? 16'(100 - (s+1)*(f+1)) : 16'(100 + (s+1)*(f+1));
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    cfg_num_samples = 8'd3; cfg_num_features = 4'd0; dist_ready = 1'b1; start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      step();
      start = (c == 4);
      check($sformatf("t3_valid_c%0d", c), 32'(dist_valid), 32'(c == 10 || c == 20 || c == 30));
      if (c == 10 || c == 20 || c == 30) begin
        check($sformatf("t3_index_c%0d", c), 32'(dist_index), 32'(c/10 - 1));
        check($sformatf("t3_data_c%0d", c), dist_data, exp3[c/10 - 1]);
      end
      check($sformatf("t3_done_c%0d", c), 32'(done), 32'(c == 31));
    end
    bad = 0;
    for (int i = 0; i < 24; i++) if (rd_cnt[i] != 1) bad++;
    check("t3_addr_once", 32'(bad), 32'd0);
    check("t3_read_total", 32'(rd_total), 32'd24);

    // Backpressure: three features of sample 0 (diffs 1,2,3), consumer stalls.
    dist_ready = 1'b0; cfg_num_samples = 8'd1; cfg_num_features = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    check("bp_valid", 32'(dist_valid), 32'd1);
`ifdef KNN_DIST_SQUARED_EN
    check("bp_data", dist_data, 32'd14);
`else
    check("bp_data", dist_data, 32'd6);
`endif
    bp_data = dist_data;
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("bp_hold_valid_%0d", k), 32'(dist_valid), 32'd1);
      check($sformatf("bp_hold_data_%0d", k), dist_data, bp_data);
      check($sformatf("bp_hold_index_%0d", k), 32'(dist_index), 32'd0);
      check($sformatf("bp_no_ren_%0d", k), 32'({sample_ren, test_ren}), 32'd0);
    end
    dist_ready = 1'b1;
    step();
    check("bp_done", 32'({done, dist_valid}), 32'b10);

    // Zero samples: immediate done, no reads, no output.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    cfg_num_samples = 8'd0; cfg_num_features = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    check("ns0_done", 32'(done), 32'd1);
    check("ns0_busy", 32'({busy, sample_ren}), 32'd0);
    step();
    step();
    check("ns0_done_clear", 32'({done, dist_valid}), 32'd0);
    check("ns0_no_reads", 32'(rd_total), 32'd0);

    // Abort during FETCH cycle 3, then a clean rerun from address 0.
    cfg_num_samples = 8'd1; cfg_num_features = 4'd8; dist_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'({busy, sample_ren, test_ren, dist_valid, done}), 32'd0);
    check("abort_acc", dist_data, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("abort_quiet_%0d", k), 32'({done, dist_valid}), 32'd0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("rerun_addr0", 32'({sample_ren, sample_raddr}), 32'({1'b1, 10'd0}));
    wait_valid("rerun_valid");
    check("rerun_data", dist_data, exp3[0]);
    check("rerun_index", 32'(dist_index), 32'd0);
    dist_ready = 1'b1;
    step();
    check("rerun_done", 32'(done), 32'd1);

    // Saturation: 8 features at full-scale difference; cfg_num_features=12 clamps to 8.
    for (int f = 0; f < 8; f++) begin
      test_mem[f] = 16'd0;
      sample_mem[f] = 16'hFFFF;
    end
    cfg_num_samples = 8'd1; cfg_num_features = 4'd12; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("sat_valid");
`ifdef KNN_DIST_SQUARED_EN
    check("sat_data", dist_data, 32'hFFFF_FFFF);
`else
    check("sat_data", dist_data, 32'h0007_FFF8);
`endif
    step();

    // Asynchronous reset in the middle of a run.
    dist_ready = 1'b0; cfg_num_samples = 8'd3; cfg_num_features = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    check("mid_rst_ctrl", 32'({busy, sample_ren, test_ren, dist_valid, done}), 32'd0);
    check("mid_rst_addr", 32'({sample_raddr, test_raddr}), 32'd0);
    check("mid_rst_data", dist_data, 32'd0);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
